iqueue_param: RTL and testbench

//  Parametrised instruction queue between IFetch and the issue MUX/decoder; successor to the fixed 16-entry queue.

---
 rtl/iqueue_param_if.sv | 44 ++++
 rtl/iqueue_param.sv | 116 +++++++++++
 tb/tb_iqueue_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iqueue_param_if.sv
// -----------------------------------------------------------------------------
// iqueue_param_if
// Handshake/bus bundle between IFetch, the instruction queue and the issue stage.
//   master : the fetch/issue side (drives enqueue data, readiness, flush, rdy)
//   slave  : the queue itself (drives occupancy, head view and issued instruction)
// Signals:
//   rdy, flush, inst_rdy, inst, pc_in        fetch-side controls and enqueue data
//   op1_rdy, op2_rdy, issue_rdy              issue-side readiness
//   q_full, q_count, overflow                occupancy / backpressure status
//   head_vld, head_inst                      combinational head view
//   ins_rdy, inst_out, pc_out                registered issue output
// -----------------------------------------------------------------------------
interface iqueue_param_if #(
  parameter int IW = 32,
  parameter int AW = 32,
  parameter int CW = 5
);
  logic          rdy;
  logic          flush;
  logic          inst_rdy;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc_in;
  logic          q_full;
  logic [CW-1:0] q_count;
  logic          overflow;
  logic          head_vld;
  logic [IW-1:0] head_inst;
  logic          op1_rdy;
  logic          op2_rdy;
  logic          issue_rdy;
  logic          ins_rdy;
  logic [IW-1:0] inst_out;
  logic [AW-1:0] pc_out;

  modport master (
    output rdy, flush, inst_rdy, inst, pc_in, op1_rdy, op2_rdy, issue_rdy,
    input  q_full, q_count, overflow, head_vld, head_inst, ins_rdy, inst_out, pc_out
  );

  modport slave (
    input  rdy, flush, inst_rdy, inst, pc_in, op1_rdy, op2_rdy, issue_rdy,
    output q_full, q_count, overflow, head_vld, head_inst, ins_rdy, inst_out, pc_out
  );
endinterface

// File: rtl/iqueue_param.sv
// -----------------------------------------------------------------------------
// iqueue_param
// Parametrised circular instruction queue between IFetch and the issue stage.
// Buffers (inst, pc) pairs, shows the head instruction combinationally for
// register-ready lookup and issues one instruction per cycle on a registered
// output. Supports redirect flush, almost-full backpressure with fetch slack
// and a sticky overflow flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : iqueue_param_if.slave (enqueue, issue readiness, status, issue output)
// -----------------------------------------------------------------------------
module iqueue_param #(
  parameter int DEPTH = 16,
  parameter int IW    = 32,
  parameter int AW    = 32,
  parameter int SLACK = 2
) (
  input  logic             clk,
  input  logic             rst,
  iqueue_param_if.slave    bus
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_ins_rdy;
  logic [IW-1:0] r_inst_out;
  logic [AW-1:0] r_pc_out;
  logic          r_overflow;
  logic [IW-1:0] r_mem_inst [DEPTH];
  logic [AW-1:0] r_mem_pc   [DEPTH];

  logic [PW-1:0] w_count;
  logic          w_head_vld;
  logic          w_at_cap;
  logic          w_enq;
  logic          w_ovf_set;
  logic          w_deq;
  logic [IW-1:0] w_head_inst;

  // Occupancy falls out of the pointer difference; modulo-2^PW wrap is intended.
  assign w_count    = r_tail - r_head;
  assign w_head_vld = (w_count != {PW{1'b0}});
  assign w_at_cap   = (w_count == PW'(DEPTH));

  // Enqueue and overflow are judged on the pre-edge count, so a dequeue in the
  // same cycle does not make room for a write at capacity.
  assign w_enq     = bus.inst_rdy & ~w_at_cap & ~bus.flush;
  assign w_ovf_set = bus.inst_rdy &  w_at_cap & ~bus.flush;
  assign w_deq     = w_head_vld & bus.issue_rdy & bus.op1_rdy & bus.op2_rdy & ~bus.flush;

  // Head view for register-ready lookup; forced to zero when the queue is empty.
  always_comb begin
    w_head_inst = {IW{1'b0}};
    if (w_head_vld) begin
      w_head_inst = r_mem_inst[r_head[PW-2:0]];
    end else begin
      w_head_inst = {IW{1'b0}};
    end
  end

  // Storage write port; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.rdy && w_enq) begin
      r_mem_inst[r_tail[PW-2:0]] <= bus.inst;
      r_mem_pc[r_tail[PW-2:0]]   <= bus.pc_in;
    end
  end

  // Pointers, issue register and sticky overflow; rdy=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= {PW{1'b0}};
      r_tail     <= {PW{1'b0}};
      r_ins_rdy  <= 1'b0;
      r_inst_out <= {IW{1'b0}};
      r_pc_out   <= {AW{1'b0}};
      r_overflow <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        // Redirect: drop everything, keep overflow history and last issued data.
        r_head    <= {PW{1'b0}};
        r_tail    <= {PW{1'b0}};
        r_ins_rdy <= 1'b0;
      end else begin
        if (w_enq) begin
          r_tail <= r_tail + PW'(1);
        end
        if (w_deq) begin
          r_head     <= r_head + PW'(1);
          r_inst_out <= r_mem_inst[r_head[PW-2:0]];
          r_pc_out   <= r_mem_pc[r_head[PW-2:0]];
          r_ins_rdy  <= 1'b1;
        end else begin
          r_ins_rdy  <= 1'b0;
        end
        if (w_ovf_set) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.q_count   = w_count;
  assign bus.q_full    = (w_count >= PW'(DEPTH - SLACK));
  assign bus.overflow  = r_overflow;
  assign bus.head_vld  = w_head_vld;
  assign bus.head_inst = w_head_inst;
  assign bus.ins_rdy   = r_ins_rdy;
  assign bus.inst_out  = r_inst_out;
  assign bus.pc_out    = r_pc_out;

endmodule

// File: tb/tb_iqueue_param.sv
// -----------------------------------------------------------------------------
// tb_iqueue_param
// Self-checking bench for iqueue_param: a reference FIFO model feeds a
// scoreboard of expected issued (inst, pc) pairs; a vector table covers basic
// enqueue/issue/freeze/flush behaviour and hand sequences cover wrap, overflow,
// concurrency, operand stall, flush and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_iqueue_param;
  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int SLACK = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  iqueue_param_if #(.IW(IW), .AW(AW), .CW(CW)) bus ();

  iqueue_param #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .SLACK(SLACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } item_t;

  typedef struct {
    logic ir, is, o1, o2, fl, rd;
    int   exp_cnt;
    logic exp_ins;
  } vec_t;

  item_t mq[$];     // reference queue contents
  item_t sb[$];     // expected issued items, pushed at issue, popped at output
  item_t m_last;    // expected inst_out/pc_out
  logic  m_ovf;
  logic  m_ins;
  logic  m_new;
  int    seq;
  int    n_chk;
  int    n_err;
  vec_t  vt [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_ins  = 1'b0;
    m_new  = 1'b0;
  endtask

  task automatic check_all();
    item_t it;
    if (m_new) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard_empty: got 0 items expected 1");
      end else begin
        it     = sb.pop_front();
        m_last = it;
      end
    end
    chk("ins_rdy",   {63'd0, bus.ins_rdy},  {63'd0, m_ins});
    chk("inst_out",  {32'd0, bus.inst_out}, {32'd0, m_last.inst});
    chk("pc_out",    {32'd0, bus.pc_out},   {32'd0, m_last.pc});
    chk("q_count",   {59'd0, bus.q_count},  64'(mq.size()));
    chk("overflow",  {63'd0, bus.overflow}, {63'd0, m_ovf});
    chk("head_vld",  {63'd0, bus.head_vld}, {63'd0, (mq.size() != 0)});
    chk("head_inst", {32'd0, bus.head_inst}, {32'd0, (mq.size() != 0) ? mq[0].inst : 32'd0});
    chk("q_full",    {63'd0, bus.q_full},   {63'd0, (mq.size() >= DEPTH - SLACK)});
  endtask

  task automatic drive(input logic ir, input logic is, input logic o1, input logic o2,
                       input logic fl, input logic rd);
    bus.inst_rdy  = ir;
    bus.issue_rdy = is;
    bus.op1_rdy   = o1;
    bus.op2_rdy   = o2;
    bus.flush     = fl;
    bus.rdy       = rd;
    bus.inst      = 32'hA000_0000 + 32'(seq);
    bus.pc_in     = 32'h0000_1000 + 32'(seq * 4);
    if (ir) seq++;
  endtask

  // Advance one clock: update the model from the applied inputs, then compare.
  task automatic cycle();
    int    pre;
    item_t it;
    pre   = mq.size();
    m_new = 1'b0;
    if (bus.rdy) begin
      if (bus.flush) begin
        mq.delete();
        m_ins = 1'b0;
      end else begin
        if (pre > 0 && bus.issue_rdy && bus.op1_rdy && bus.op2_rdy) begin
          it = mq.pop_front();
          sb.push_back(it);
          m_ins = 1'b1;
          m_new = 1'b1;
        end else begin
          m_ins = 1'b0;
        end
        if (bus.inst_rdy && pre < DEPTH) begin
          it.inst = bus.inst;
          it.pc   = bus.pc_in;
          mq.push_back(it);
        end
        if (bus.inst_rdy && pre == DEPTH) m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic step(input logic ir, input logic is, input logic o1, input logic o2,
                      input logic fl, input logic rd);
    drive(ir, is, o1, o2, fl, rd);
    cycle();
  endtask

  initial begin
    item_t saved;
    n_chk = 0;
    n_err = 0;
    seq   = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ir, is, o1, o2, fl, rd, count after, ins_rdy after
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vt[i].ir, vt[i].is, vt[i].o1, vt[i].o2, vt[i].fl, vt[i].rd);
      chk($sformatf("vec%0d_count", i), {59'd0, bus.q_count}, 64'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_ins", i), {63'd0, bus.ins_rdy}, {63'd0, vt[i].exp_ins});
    end

    // Fill to the almost-full threshold, drain, then stream 20 through the wrap.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fill13_q_full", {63'd0, bus.q_full}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fill14_q_full", {63'd0, bus.q_full}, 64'd1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow: 16 stored, 17th dropped, then concurrent at capacity.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovf_count", {59'd0, bus.q_count}, 64'd16);
    chk("ovf_flag", {63'd0, bus.overflow}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("cap_concurrent_count", {59'd0, bus.q_count}, 64'd15);
    chk("cap_concurrent_ins", {63'd0, bus.ins_rdy}, 64'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", {63'd0, bus.overflow}, 64'd1);

    // Concurrent enqueue and issue at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("cnt3_concurrent", {59'd0, bus.q_count}, 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Operand stall on a single head entry.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    saved = mq[0];
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("stall_ins", {63'd0, bus.ins_rdy}, 64'd0);
      chk("stall_head", {32'd0, bus.head_inst}, {32'd0, saved.inst});
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stall_release_ins", {63'd0, bus.ins_rdy}, 64'd1);
    chk("stall_release_pc", {32'd0, bus.pc_out}, {32'd0, saved.pc});

    // Flush at count 7 with enqueue and issue requested in the same cycle.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_count", {59'd0, bus.q_count}, 64'd0);
    chk("flush_ins", {63'd0, bus.ins_rdy}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("post_flush_ins", {63'd0, bus.ins_rdy}, 64'd1);

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_count", {59'd0, bus.q_count}, 64'd0);
    chk("rst_head_vld", {63'd0, bus.head_vld}, 64'd0);
    chk("rst_ins", {63'd0, bus.ins_rdy}, 64'd0);
    chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
